// File: rtl/mul_div_unit_pkg.sv
// Shared types for the multiply/divide unit: opcode and FSM state encodings
// plus small helpers used by the top level.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } mdu_state_e;

  // Iteration counter width able to hold WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bus between the EXEC stage (master) and the multiply/divide unit (slave).
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// Unsigned restoring radix-2 divider datapath: load latches operands, each step
// retires one quotient bit; after WIDTH steps quotient/remainder are final.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   partial;
  logic             fits;

  // Partial remainder is always below the divisor, so one extra bit suffices.
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign fits    = partial >= {1'b0, dvs_q};

  // NOTE: pure datapath registers carry no reset; every use is preceded by a load.
  always_ff @(posedge clk) begin
    if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= fits ? partial[WIDTH-1:0] - dvs_q : partial[WIDTH-1:0];
      quo_q <= {quo_q[WIDTH-2:0], fits};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Signed operations run on
// magnitudes; the FIX state applies result signs before HI/LO are written.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter bit MUL_ITERATIVE = 1'b0
) (
  input logic           clk,
  input logic           reset,
  mul_div_unit_if.slave bus
);
  localparam int CNT_W = cnt_width(WIDTH);

  typedef logic [WIDTH-1:0]   word_t;
  typedef logic [2*WIDTH-1:0] dword_t;

  function automatic word_t magnitude(input word_t x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? word_t'(-x) : x;
  endfunction

  function automatic dword_t extend(input word_t x, input logic sgn);
    return sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
  endfunction

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q, done_q, dbz_q;
  word_t            hi_q, lo_q;
  logic             is_div, res_neg, rem_neg, zero_div, sgn_q;
  dword_t           mcand, acc;
  word_t            mplier, quo, rem;

  mdu_op_e op;
  logic    issue, op_sgn, rt_zero, is_mul_op, is_div_op;
  word_t   rs_mag, rt_mag;

  assign op        = mdu_op_e'(bus.op);
  assign issue     = bus.start && (state == IDLE) && op_legal(bus.op);
  assign op_sgn    = (op == OP_MULT) || (op == OP_DIV);
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
  assign rt_zero   = (bus.rt_data == '0);
  assign rs_mag    = magnitude(bus.rs_data, op_sgn);
  assign rt_mag    = magnitude(bus.rt_data, op_sgn);

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .load      (issue && is_div_op && !rt_zero),
    .step      (state == DIV),
    .dividend  (rs_mag),
    .divisor   (rt_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  dword_t comb_prod, fix_prod;
  word_t  fix_quo, fix_rem;

  assign comb_prod = mcand * extend(mplier, sgn_q);
  assign fix_prod  = res_neg ? dword_t'(-acc) : acc;
  assign fix_quo   = res_neg ? word_t'(-quo) : quo;
  assign fix_rem   = rem_neg ? word_t'(-rem) : rem;

  // Multiplier datapath: raw extended operands for the one-cycle product,
  // magnitudes with shift-add accumulation for the iterative variant.
  always_ff @(posedge clk) begin
    if (issue && is_mul_op) begin
      sgn_q <= op_sgn;
      acc   <= '0;
      if (MUL_ITERATIVE) begin
        mcand  <= {{WIDTH{1'b0}}, rs_mag};
        mplier <= rt_mag;
      end else begin
        mcand  <= extend(bus.rs_data, op_sgn);
        mplier <= bus.rt_data;
      end
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      // NOTE: done/div_by_zero default low each cycle so any set below is a one-cycle pulse.
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          case (op)
            OP_MTHI: begin
              hi_q   <= bus.rs_data;
              done_q <= 1'b1;
            end
            OP_MTLO: begin
              lo_q   <= bus.rs_data;
              done_q <= 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              state   <= MUL;
              busy_q  <= 1'b1;
              is_div  <= 1'b0;
              cnt     <= CNT_W'(WIDTH - 1);
              res_neg <= op_sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
            end
            OP_DIV, OP_DIVU: begin
              state    <= rt_zero ? FIX : DIV;
              busy_q   <= 1'b1;
              is_div   <= 1'b1;
              zero_div <= rt_zero;
              cnt      <= CNT_W'(WIDTH - 1);
              res_neg  <= op_sgn && (bus.rs_data[WIDTH-1] ^ bus.rt_data[WIDTH-1]);
              rem_neg  <= op_sgn && bus.rs_data[WIDTH-1];
            end
            default: ;
          endcase
        end
        MUL: begin
          if (!MUL_ITERATIVE) begin
            {hi_q, lo_q} <= comb_prod;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state        <= IDLE;
          end else if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (zero_div)    dbz_q        <= 1'b1;
          else if (is_div) {hi_q, lo_q} <= {fix_rem, fix_quo};
          else             {hi_q, lo_q} <= fix_prod;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule
